// File: rtl/ddr3_arb_pkg.sv
// Shared constants and FSM state encoding for the DDR3 multi-port arbiter.
package ddr3_arb_pkg;

    localparam logic [2:0] CMD_WRITE  = 3'b000;
    localparam logic [2:0] CMD_READ   = 3'b001;
    localparam int         LANE_WIDTH = 32;
    localparam int         LANE_BYTES = LANE_WIDTH / 8;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WRITE,
        ST_READ_CMD,
        ST_READ_WAIT,
        ST_DONE
    } arb_state_t;

endpackage

// File: rtl/ddr3_port_arbiter_rr.sv
// Combinational round-robin arbiter: grants the first requester after 'last',
// wrapping around to the lowest index.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     grant
);

    logic [N-1:0] grant_hi;
    logic [N-1:0] grant_lo;

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        grant_hi = '0;
        grant_lo = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_lo    = '0;
                grant_lo[i] = 1'b1;
                if (i > int'(last)) begin
                    grant_hi    = '0;
                    grant_hi[i] = 1'b1;
                end
            end
        end
        grant = (|grant_hi) ? grant_hi : grant_lo;
    end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Multi-port arbiter that funnels single-word client reads/writes into
// single-beat 128-bit DDR3 controller commands.
module ddr3_port_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int PORT_ADDR_WIDTH = 27,
    parameter int DDR_ADDR_WIDTH  = 29,
    parameter int DDR_DATA_WIDTH  = 128
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PORT_ADDR_WIDTH-1:0] port_addr      [NUM_PORTS],
    input  logic [LANE_WIDTH-1:0]      port_data      [NUM_PORTS],
    input  logic [3:0]                 port_byte_en   [NUM_PORTS],
    input  logic                       port_wr        [NUM_PORTS],
    input  logic                       port_rd        [NUM_PORTS],
    output logic [LANE_WIDTH-1:0]      port_q         [NUM_PORTS],
    output logic                       port_ready     [NUM_PORTS],
    output logic                       port_available [NUM_PORTS],
    input  logic                       init_calib_complete,
    input  logic                       cmd_ready,
    output logic [2:0]                 cmd,
    output logic                       cmd_en,
    output logic [DDR_ADDR_WIDTH-1:0]  addr,
    input  logic                       wr_data_rdy,
    output logic [DDR_DATA_WIDTH-1:0]  wr_data,
    output logic                       wr_data_en,
    output logic                       wr_data_end,
    output logic [DDR_DATA_WIDTH/8-1:0] wr_data_mask,
    input  logic [DDR_DATA_WIDTH-1:0]  rd_data,
    input  logic                       rd_data_valid,
    input  logic                       rd_data_end
);

    localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int NUM_LANES = DDR_DATA_WIDTH / LANE_WIDTH;
    localparam int MASK_W    = DDR_DATA_WIDTH / 8;

    arb_state_t state_reg, state_next;
    logic [IDX_W-1:0] last_reg, last_next;

    logic                       pend_reg      [NUM_PORTS];
    logic                       pend_wr_reg   [NUM_PORTS];
    logic [PORT_ADDR_WIDTH-1:0] pend_addr_reg [NUM_PORTS];
    logic [LANE_WIDTH-1:0]      pend_data_reg [NUM_PORTS];
    logic [3:0]                 pend_be_reg   [NUM_PORTS];

    logic [NUM_PORTS-1:0] req_vec;
    logic [NUM_PORTS-1:0] pend_wr_vec;
    logic [NUM_PORTS-1:0] grant_vec;
    logic [IDX_W-1:0]     grant_idx;

    logic [PORT_ADDR_WIDTH-1:0] sel_addr;
    logic [LANE_WIDTH-1:0]      sel_data;
    logic [3:0]                 sel_be;
    logic [1:0]                 sel_lane;
    logic [PORT_ADDR_WIDTH:0]   sel_ddr_full;
    logic [DDR_ADDR_WIDTH-1:0]  sel_ddr_addr;
    logic [MASK_W-1:0]          sel_mask;
    logic [LANE_WIDTH-1:0]      rd_lane_data;

    // Every read is a single 128-bit beat, so the end-of-burst flag carries no extra information.
    logic unused_rd_end;
    assign unused_rd_end = rd_data_end;

    rr_arbiter #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (req_vec),
        .last  (last_reg),
        .grant (grant_vec)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_vec[i]) grant_idx = IDX_W'(i);
        end
    end

    // last_reg doubles as the index of the port being served once granted.
    assign sel_addr     = pend_addr_reg[last_reg];
    assign sel_data     = pend_data_reg[last_reg];
    assign sel_be       = pend_be_reg[last_reg];
    assign sel_lane     = sel_addr[1:0];
    assign sel_ddr_full = {sel_addr[PORT_ADDR_WIDTH-1:2], 3'b000};
    assign sel_ddr_addr = DDR_ADDR_WIDTH'(sel_ddr_full);

    always_comb begin
        sel_mask     = '1;
        rd_lane_data = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (sel_lane == 2'(l)) begin
                sel_mask[LANE_BYTES*l +: LANE_BYTES] = ~sel_be;
                rd_lane_data = rd_data[LANE_WIDTH*l +: LANE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_INIT;
            last_reg  <= IDX_W'(NUM_PORTS - 1);
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        last_next    = last_reg;
        cmd          = CMD_WRITE;
        cmd_en       = 1'b0;
        addr         = '0;
        wr_data      = '0;
        wr_data_en   = 1'b0;
        wr_data_end  = 1'b0;
        wr_data_mask = '1;
        case (state_reg)
            ST_INIT: begin
                if (init_calib_complete) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (|req_vec) begin
                    last_next  = grant_idx;
                    state_next = pend_wr_vec[grant_idx] ? ST_WRITE : ST_READ_CMD;
                end
            end
            ST_WRITE: begin
                cmd          = CMD_WRITE;
                addr         = sel_ddr_addr;
                wr_data      = {NUM_LANES{sel_data}};
                wr_data_mask = sel_mask;
                if (cmd_ready && wr_data_rdy) begin
                    cmd_en      = 1'b1;
                    wr_data_en  = 1'b1;
                    wr_data_end = 1'b1;
                    state_next  = ST_DONE;
                end
            end
            ST_READ_CMD: begin
                cmd  = CMD_READ;
                addr = sel_ddr_addr;
                if (cmd_ready) begin
                    cmd_en     = 1'b1;
                    state_next = ST_READ_WAIT;
                end
            end
            ST_READ_WAIT: begin
                if (rd_data_valid) state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        logic is_sel;
        logic take;

        assign is_sel  = (last_reg == IDX_W'(gi));
        // A strobe is only taken by an idle slot once calibration is done.
        assign take    = (state_reg != ST_INIT) && !pend_reg[gi] && (port_wr[gi] || port_rd[gi]);
        assign req_vec[gi]     = pend_reg[gi];
        assign pend_wr_vec[gi] = pend_wr_reg[gi];
        assign port_available[gi] = (state_reg != ST_INIT) && !pend_reg[gi];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pend_reg[gi]      <= 1'b0;
                pend_wr_reg[gi]   <= 1'b0;
                pend_addr_reg[gi] <= '0;
                pend_data_reg[gi] <= '0;
                pend_be_reg[gi]   <= '0;
            end else if (state_reg == ST_DONE && is_sel) begin
                pend_reg[gi] <= 1'b0;
            end else if (take) begin
                pend_reg[gi]      <= 1'b1;
                pend_wr_reg[gi]   <= port_wr[gi];
                pend_addr_reg[gi] <= port_addr[gi];
                pend_data_reg[gi] <= port_data[gi];
                pend_be_reg[gi]   <= port_byte_en[gi];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                port_q[gi]     <= '0;
                port_ready[gi] <= 1'b0;
            end else begin
                port_ready[gi] <= (state_reg == ST_DONE) && is_sel;
                if (state_reg == ST_READ_WAIT && rd_data_valid && is_sel) begin
                    port_q[gi] <= rd_lane_data;
                end
            end
        end
    end

endmodule

// File: doc/ddr3_port_arbiter.md
DDR3_PORT_ARBITER -- requirements
Module: ddr3_port_arbiter

Interface
REQ-001 SHALL take parameter NUM_PORTS, default 4: number of client ports, 1..8.
REQ-002 SHALL take parameter PORT_ADDR_WIDTH, default 27: client 32-bit word address width.
REQ-003 SHALL take parameter DDR_ADDR_WIDTH, default 29: DDR3 address width, in 16-bit units.
REQ-004 SHALL take parameter DDR_DATA_WIDTH, default 128: DDR3 burst width, fixed at 128.
REQ-005 SHALL have the following ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- port_addr[NUM_PORTS]  in  PORT_ADDR_WIDTH  word address.
- port_data[NUM_PORTS]  in  32  write data.
- port_byte_en[NUM_PORTS]  in  4  byte enables, active-high.
- port_wr[NUM_PORTS]  in  1  one-cycle write strobe.
- port_rd[NUM_PORTS]  in  1  one-cycle read strobe.
- port_q[NUM_PORTS]  out  32  read data.
- port_ready[NUM_PORTS]  out  1  one-cycle completion pulse.
- port_available[NUM_PORTS]  out  1  port can accept a strobe.
- init_calib_complete  in  1.
- cmd_ready  in  1.
- cmd  out  3.
- cmd_en  out  1.
- addr  out  DDR_ADDR_WIDTH.
- wr_data_rdy  in  1.
- wr_data  out  128.
- wr_data_en  out  1.
- wr_data_end  out  1.
- wr_data_mask  out  16  1 = byte masked.
- rd_data  in  128.
- rd_data_valid  in  1.
- rd_data_end  in  1.

Function
REQ-006 SHALL latch a strobe into a per-port pending slot (op, addr, data, byte_en) on the strobe cycle; port_available SHALL go low the next cycle and stay low until port_ready.
REQ-007 SHALL ignore strobes while the port is pending; if wr and rd arrive in the same cycle, wr SHALL win and rd SHALL be dropped.
REQ-008 SHALL run FSM INIT -> IDLE -> {WRITE | READ_CMD -> READ_WAIT} -> DONE -> IDLE.
REQ-009 SHALL stay in INIT until init_calib_complete=1, and hold all port_available low while in INIT.
REQ-010 IDLE SHALL grant round-robin, starting at the port after the last granted port (port 0 first after reset), and evaluate pending slots only.
REQ-011 SHALL set addr = {word_addr[PORT_ADDR_WIDTH-1:2], 3'b000}, zero-extended or truncated to DDR_ADDR_WIDTH; lane = word_addr[1:0].
REQ-012 WRITE SHALL assert cmd_en=1, cmd=3'b000, wr_data_en=1 and wr_data_end=1 in the same cycle, only when cmd_ready=1 and wr_data_rdy=1; otherwise it SHALL hold.
REQ-013 Write data SHALL be port_data replicated to all 4 lanes; wr_data_mask SHALL be all ones except bits [4*lane+3:4*lane] = ~byte_en.
REQ-014 READ_CMD SHALL assert cmd_en=1, cmd=3'b001 when cmd_ready=1, then move to READ_WAIT.
REQ-015 READ_WAIT SHALL capture rd_data[32*lane+31:32*lane] into port_q on the first rd_data_valid cycle, then move to DONE.
REQ-016 DONE SHALL pulse port_ready of the granted port for exactly 1 cycle, clear its pending slot, and return to IDLE.
REQ-017 Write latency, strobe to port_ready, SHALL be 4 cycles with ready inputs high; read latency SHALL be DDR latency + 4 cycles.
REQ-018 port_q SHALL hold its last value until the next read completion on that port; writes SHALL NOT alter port_q.
REQ-019 rd_data_valid outside READ_WAIT SHALL be ignored.
REQ-020 cmd_en and wr_data_en SHALL be asserted only in the cycle a command is accepted.

Reset
REQ-021 Reset SHALL force state INIT, clear all pending slots, set the round-robin pointer to the last port, and drive cmd_en, wr_data_en, wr_data_end and port_ready to 0, cmd to 0, addr to 0, wr_data to 0, wr_data_mask to all ones, port_q to 0 and port_available to 0.
REQ-022 Reset mid-operation SHALL abandon the transfer with no port_ready pulse; late rd_data_valid SHALL be discarded per REQ-019.

Structure
REQ-023 Package ddr3_arb_pkg SHALL hold the command codes (CMD_WRITE=3'b000, CMD_READ=3'b001), the FSM state enum, and the lane width constant 32.
REQ-024 SHALL contain exactly one sub-module, rr_arbiter (request vector plus last-grant in, one-hot grant out, combinational), reused per NUM_PORTS.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Calibration gate: init_calib_complete=0 for 50 cycles with strobes applied -> no cmd_en, available=0; after it rises, available=1 the next cycle.
- Single write: port 1, addr 0x00000006, data 0xDEADBEEF, byte_en 4'b0011 -> addr 0x8, cmd 0, mask 16'hFCFF, wr_data 0xDEADBEEF replicated, ready pulse at cycle 4.
- Single read: port 0, addr 0x7 with rd_data returning 128'h33333333_22222222_11111111_00000000 -> port_q = 0x33333333, one ready pulse.
- Fairness: all 4 ports strobe reads in the same cycle -> grants 0,1,2,3; a second round starting at port 1 grants 1,2,3,0.
- Backpressure: cmd_ready=0 for 10 cycles -> cmd_en stays 0 and the request is held; the command issues in the cycle cmd_ready rises.
- Reset during READ_WAIT, then rd_data_valid arrives -> no port_ready, port_q=0, FSM in INIT.
